// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared FSM encoding and owner constants for the SRAM bus arbiter
package arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } arb_state_t;

    localparam logic OWN_INST = 1'b0;
    localparam logic OWN_DATA = 1'b1;

endpackage

// File: rtl/sram_arb_pick.sv
// rtl/sram_arb_pick.sv - picks fetch or data side from eligibility and last grant
module sram_arb_pick #(
    parameter int DATA_PRIO = 1
) (
    input  logic i_elig,
    input  logic d_elig,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant_owner
);
    import arb_pkg::*;

    // Tie goes to data under fixed priority, otherwise to the side not served last.
    always_comb begin
        grant_valid = i_elig | d_elig;
        grant_owner = OWN_INST;
        if (i_elig && d_elig) begin
            if (DATA_PRIO != 0) begin
                grant_owner = OWN_DATA;
            end else begin
                grant_owner = (last_grant == OWN_INST) ? OWN_DATA : OWN_INST;
            end
        end else if (d_elig) begin
            grant_owner = OWN_DATA;
        end
    end

endmodule

// File: rtl/sram_bus_arbiter.sv
// rtl/sram_bus_arbiter.sv - shares one SRAM-like port between fetch and data sides
module sram_bus_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int DATA_PRIO = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_data_ok,
    input  logic              d_req,
    input  logic [3:0]        d_wen,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_data_ok,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [3:0]        mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_addr_ok,
    input  logic              mem_data_ok,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall
);
    import arb_pkg::*;

    arb_state_t state;
    arb_state_t state_next;
    logic       owner;
    logic       last_grant;
    logic       grant_valid;
    logic       grant_owner;
    logic       done;

    // A side whose completion pulse is showing this cycle is not eligible again yet.
    sram_arb_pick #(
        .DATA_PRIO (DATA_PRIO)
    ) u_pick (
        .i_elig      (i_req & ~i_data_ok),
        .d_elig      (d_req & ~d_data_ok),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );

    assign mem_wr = |mem_wen;
    assign stall  = (i_req & ~i_data_ok) | (d_req & ~d_data_ok);

    // Next state and the transfer-complete strobe (addr+data together finishes from ADDR).
    always_comb begin
        state_next = state;
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (grant_valid) state_next = ST_ADDR;
            end
            ST_ADDR: begin
                if (mem_addr_ok) begin
                    if (mem_data_ok) begin
                        state_next = ST_IDLE;
                        done       = 1'b1;
                    end else begin
                        state_next = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (mem_data_ok) begin
                    state_next = ST_IDLE;
                    done       = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State register, captured request fields, and per-owner completion results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            owner      <= OWN_INST;
            last_grant <= OWN_INST;
            mem_req    <= 1'b0;
            mem_wen    <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            i_rdata    <= '0;
            d_rdata    <= '0;
            i_data_ok  <= 1'b0;
            d_data_ok  <= 1'b0;
        end else begin
            state     <= state_next;
            i_data_ok <= done && (owner == OWN_INST);
            d_data_ok <= done && (owner == OWN_DATA);
            if (done && (mem_wen == 4'd0)) begin
                if (owner == OWN_DATA) d_rdata <= mem_rdata;
                else                   i_rdata <= mem_rdata;
            end
            case (state)
                ST_IDLE: begin
                    if (grant_valid) begin
                        owner      <= grant_owner;
                        last_grant <= grant_owner;
                        mem_req    <= 1'b1;
                        if (grant_owner == OWN_DATA) begin
                            mem_addr  <= d_addr;
                            mem_wen   <= d_wen;
                            mem_wdata <= d_wdata;
                        end else begin
                            mem_addr  <= i_addr;
                            mem_wen   <= 4'd0;
                            mem_wdata <= '0;
                        end
                    end
                end
                ST_ADDR: begin
                    if (mem_addr_ok) mem_req <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// tb/tb_sram_bus_arbiter.sv - self-checking bench: fixed-priority and round-robin instances vs transaction model
module tb_sram_bus_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // index 0: DATA_PRIO=1, index 1: DATA_PRIO=0
    logic [1:0]       i_req, d_req, mem_addr_ok, mem_data_ok;
    logic [1:0][31:0] i_addr, d_addr, d_wdata, mem_rdata;
    logic [1:0][3:0]  d_wen;
    logic [1:0][31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
    logic [1:0]       i_data_ok, d_data_ok, mem_req, mem_wr, stall;
    logic [1:0][3:0]  mem_wen;

    sram_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .DATA_PRIO(1)) dut_prio (
        .clk(clk), .rst(rst),
        .i_req(i_req[0]), .i_addr(i_addr[0]), .i_rdata(i_rdata[0]), .i_data_ok(i_data_ok[0]),
        .d_req(d_req[0]), .d_wen(d_wen[0]), .d_addr(d_addr[0]), .d_wdata(d_wdata[0]),
        .d_rdata(d_rdata[0]), .d_data_ok(d_data_ok[0]),
        .mem_req(mem_req[0]), .mem_wr(mem_wr[0]), .mem_wen(mem_wen[0]), .mem_addr(mem_addr[0]),
        .mem_wdata(mem_wdata[0]), .mem_addr_ok(mem_addr_ok[0]), .mem_data_ok(mem_data_ok[0]),
        .mem_rdata(mem_rdata[0]), .stall(stall[0])
    );

    sram_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .DATA_PRIO(0)) dut_rr (
        .clk(clk), .rst(rst),
        .i_req(i_req[1]), .i_addr(i_addr[1]), .i_rdata(i_rdata[1]), .i_data_ok(i_data_ok[1]),
        .d_req(d_req[1]), .d_wen(d_wen[1]), .d_addr(d_addr[1]), .d_wdata(d_wdata[1]),
        .d_rdata(d_rdata[1]), .d_data_ok(d_data_ok[1]),
        .mem_req(mem_req[1]), .mem_wr(mem_wr[1]), .mem_wen(mem_wen[1]), .mem_addr(mem_addr[1]),
        .mem_wdata(mem_wdata[1]), .mem_addr_ok(mem_addr_ok[1]), .mem_data_ok(mem_data_ok[1]),
        .mem_rdata(mem_rdata[1]), .stall(stall[1])
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    bit         m_busy [2];   // a transaction is outstanding
    bit         m_acc  [2];   // slave has accepted its address
    bit         m_own  [2];   // 1 = data side owns it
    bit         m_last [2];
    bit         m_iok  [2];
    bit         m_dok  [2];
    logic [31:0] m_addr [2];
    logic [31:0] m_wdat [2];
    logic [3:0]  m_wen  [2];
    logic [31:0] m_ird  [2];
    logic [31:0] m_drd  [2];
    int          gq0[$];
    int          gq1[$];

    task automatic model_reset(input int k);
        m_busy[k] = 0; m_acc[k] = 0; m_own[k] = 0; m_last[k] = 0;
        m_iok[k] = 0; m_dok[k] = 0;
        m_addr[k] = '0; m_wdat[k] = '0; m_wen[k] = '0;
        m_ird[k] = '0; m_drd[k] = '0;
    endtask

    task automatic model_step(input int k);
        bit ni, nd, fin, ei, ed, pick;
        ni = 0; nd = 0; fin = 0;
        if (m_busy[k]) begin
            if (!m_acc[k] && mem_addr_ok[k]) begin
                m_acc[k] = 1;
                fin = mem_data_ok[k];
            end else if (m_acc[k] && mem_data_ok[k]) begin
                fin = 1;
            end
            if (fin) begin
                if (m_wen[k] == 4'd0) begin
                    if (m_own[k]) m_drd[k] = mem_rdata[k];
                    else          m_ird[k] = mem_rdata[k];
                end
                nd = m_own[k];
                ni = !m_own[k];
                m_busy[k] = 0;
                m_acc[k]  = 0;
            end
        end else begin
            ei = i_req[k] && !m_iok[k];
            ed = d_req[k] && !m_dok[k];
            if (ei || ed) begin
                if (ei && ed) pick = (k == 0) ? 1'b1 : !m_last[k];
                else          pick = ed;
                m_busy[k] = 1;
                m_own[k]  = pick;
                m_last[k] = pick;
                m_addr[k] = pick ? d_addr[k] : i_addr[k];
                m_wen[k]  = pick ? d_wen[k] : 4'd0;
                m_wdat[k] = pick ? d_wdata[k] : 32'd0;
                if (k == 0) gq0.push_back(int'(pick));
                else        gq1.push_back(int'(pick));
            end
        end
        m_iok[k] = ni;
        m_dok[k] = nd;
    endtask

    task automatic compare(input int k);
        bit er;
        er = m_busy[k] && !m_acc[k];
        check($sformatf("mem_req[%0d]", k), 32'(mem_req[k]), 32'(er));
        if (er) begin
            check($sformatf("mem_addr[%0d]", k), mem_addr[k], m_addr[k]);
            check($sformatf("mem_wen[%0d]", k), 32'(mem_wen[k]), 32'(m_wen[k]));
            check($sformatf("mem_wdata[%0d]", k), mem_wdata[k], m_wdat[k]);
            check($sformatf("mem_wr[%0d]", k), 32'(mem_wr[k]), 32'(|m_wen[k]));
        end
        check($sformatf("i_data_ok[%0d]", k), 32'(i_data_ok[k]), 32'(m_iok[k]));
        check($sformatf("d_data_ok[%0d]", k), 32'(d_data_ok[k]), 32'(m_dok[k]));
        check($sformatf("i_rdata[%0d]", k), i_rdata[k], m_ird[k]);
        check($sformatf("d_rdata[%0d]", k), d_rdata[k], m_drd[k]);
        check($sformatf("stall[%0d]", k), 32'(stall[k]),
              32'((i_req[k] & ~m_iok[k]) | (d_req[k] & ~m_dok[k])));
    endtask

    initial begin
        forever begin
            @(posedge clk);
            for (int k = 0; k < 2; k++) begin
                if (rst) model_reset(k);
                else     model_step(k);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                for (int k = 0; k < 2; k++) compare(k);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        i_req = '0; d_req = '0; mem_addr_ok = '0; mem_data_ok = '0;
        i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0; d_wen = '0;
    endtask

    int rr_got[$];
    int rr_exp[4] = '{1, 0, 1, 0};

    initial begin
        clear_inputs();
        for (int k = 0; k < 2; k++) model_reset(k);
        repeat (3) @(negedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            check("rst_mem_req", 32'(mem_req[k]), 32'd0);
            check("rst_i_data_ok", 32'(i_data_ok[k]), 32'd0);
            check("rst_d_data_ok", 32'(d_data_ok[k]), 32'd0);
            check("rst_i_rdata", i_rdata[k], 32'd0);
            check("rst_d_rdata", d_rdata[k], 32'd0);
            check("rst_mem_addr", mem_addr[k], 32'd0);
            check("rst_stall", 32'(stall[k]), 32'd0);
        end
        rst = 1'b0;
        tick();

        // single fetch, zero-wait slave
        i_req[0] = 1; i_addr[0] = 32'hBFC0_0000;
        tick();
        check("t1_mem_req", 32'(mem_req[0]), 32'd1);
        check("t1_mem_addr", mem_addr[0], 32'hBFC0_0000);
        check("t1_mem_wr", 32'(mem_wr[0]), 32'd0);
        check("t1_stall", 32'(stall[0]), 32'd1);
        mem_addr_ok[0] = 1;
        tick();
        check("t1_req_drop", 32'(mem_req[0]), 32'd0);
        mem_addr_ok[0] = 0; mem_data_ok[0] = 1; mem_rdata[0] = 32'h2408_0001;
        tick();
        check("t1_i_data_ok", 32'(i_data_ok[0]), 32'd1);
        check("t1_i_rdata", i_rdata[0], 32'h2408_0001);
        i_req[0] = 0; mem_data_ok[0] = 0; mem_rdata[0] = 0;
        tick();
        check("t1_pulse_end", 32'(i_data_ok[0]), 32'd0);
        tick();

        // simultaneous requests, fixed data priority
        gq0.delete();
        i_req[0] = 1; i_addr[0] = 32'h0000_0100;
        d_req[0] = 1; d_wen[0] = 4'b0011; d_addr[0] = 32'h0000_0010; d_wdata[0] = 32'h0000_ABCD;
        tick();
        check("t2_mem_wen", 32'(mem_wen[0]), 32'h3);
        check("t2_mem_wdata", mem_wdata[0], 32'h0000_ABCD);
        check("t2_mem_addr", mem_addr[0], 32'h0000_0010);
        check("t2_mem_wr", 32'(mem_wr[0]), 32'd1);
        mem_addr_ok[0] = 1; mem_data_ok[0] = 1; mem_rdata[0] = 32'hDEAD_BEEF;
        tick();
        check("t2_d_data_ok", 32'(d_data_ok[0]), 32'd1);
        check("t2_d_rdata_kept", d_rdata[0], 32'd0);
        check("t2_stall_fetch", 32'(stall[0]), 32'd1);
        d_req[0] = 0; mem_addr_ok[0] = 0; mem_data_ok[0] = 0;
        tick();
        check("t2_fetch_granted", 32'(mem_req[0]), 32'd1);
        check("t2_fetch_addr", mem_addr[0], 32'h0000_0100);
        check("t2_fetch_wen", 32'(mem_wen[0]), 32'd0);
        mem_addr_ok[0] = 1; mem_data_ok[0] = 1; mem_rdata[0] = 32'h1111_1111;
        tick();
        check("t2_i_data_ok", 32'(i_data_ok[0]), 32'd1);
        check("t2_i_rdata", i_rdata[0], 32'h1111_1111);
        i_req[0] = 0; mem_addr_ok[0] = 0; mem_data_ok[0] = 0;
        tick();
        check("t2_grants", 32'(gq0.size()), 32'd2);
        if (gq0.size() >= 2) begin
            check("t2_model_first", 32'(gq0[0]), 32'd1);
            check("t2_model_second", 32'(gq0[1]), 32'd0);
        end

        // round robin with both sides held
        gq1.delete();
        i_req[1] = 1; i_addr[1] = 32'h0000_00A0;
        d_req[1] = 1; d_addr[1] = 32'h0000_00D0; d_wen[1] = 4'd0;
        for (int c = 0; c < 40 && rr_got.size() < 4; c++) begin
            tick();
            if (mem_req[1]) begin
                rr_got.push_back((mem_addr[1] == 32'h0000_00D0) ? 1 : 0);
                mem_addr_ok[1] = 1; mem_data_ok[1] = 1; mem_rdata[1] = 32'(c);
            end else begin
                mem_addr_ok[1] = 0; mem_data_ok[1] = 0;
            end
        end
        tick();
        i_req[1] = 0; d_req[1] = 0; mem_addr_ok[1] = 0; mem_data_ok[1] = 0;
        tick();
        check("t3_grant_count", 32'(rr_got.size()), 32'd4);
        for (int j = 0; j < 4; j++) begin
            if (j < rr_got.size()) check($sformatf("t3_order%0d", j), 32'(rr_got[j]), 32'(rr_exp[j]));
            if (j < gq1.size())    check($sformatf("t3_model%0d", j), 32'(gq1[j]), 32'(rr_exp[j]));
        end

        // slave backpressure with stray data_ok while address not accepted
        d_req[0] = 1; d_addr[0] = 32'h0000_0044; d_wen[0] = 4'b1000; d_wdata[0] = 32'h0000_0055;
        tick();
        for (int j = 0; j < 5; j++) begin
            check("t4_mem_req", 32'(mem_req[0]), 32'd1);
            check("t4_mem_addr", mem_addr[0], 32'h0000_0044);
            check("t4_mem_wen", 32'(mem_wen[0]), 32'h8);
            check("t4_stall", 32'(stall[0]), 32'd1);
            check("t4_no_ok", 32'(d_data_ok[0]), 32'd0);
            mem_data_ok[0] = (j == 1 || j == 3);
            d_addr[0] = $urandom();
            tick();
        end
        mem_data_ok[0] = 0; mem_addr_ok[0] = 1;
        tick();
        check("t4_data_phase", 32'(mem_req[0]), 32'd0);
        mem_addr_ok[0] = 0; mem_data_ok[0] = 1; mem_rdata[0] = 32'h7777_7777;
        tick();
        check("t4_d_data_ok", 32'(d_data_ok[0]), 32'd1);
        check("t4_d_rdata_kept", d_rdata[0], 32'd0);
        d_req[0] = 0; mem_data_ok[0] = 0;
        tick();

        // combined addr_ok+data_ok on a load
        d_req[0] = 1; d_addr[0] = 32'h0000_0020; d_wen[0] = 4'd0;
        tick();
        mem_addr_ok[0] = 1; mem_data_ok[0] = 1; mem_rdata[0] = 32'h1234_5678;
        tick();
        check("t5_d_data_ok", 32'(d_data_ok[0]), 32'd1);
        check("t5_d_rdata", d_rdata[0], 32'h1234_5678);
        check("t5_idle", 32'(mem_req[0]), 32'd0);
        d_req[0] = 0; mem_addr_ok[0] = 0; mem_data_ok[0] = 0;
        tick();
        check("t5_pulse_end", 32'(d_data_ok[0]), 32'd0);

        // asynchronous reset while waiting in the data phase
        d_req[0] = 1; d_addr[0] = 32'h0000_0080; d_wen[0] = 4'd0;
        tick();
        mem_addr_ok[0] = 1;
        tick();
        mem_addr_ok[0] = 0;
        check("t6_in_data", 32'(mem_req[0]), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        check("t6_rst_d_rdata", d_rdata[0], 32'd0);
        check("t6_rst_i_rdata", i_rdata[0], 32'd0);
        check("t6_rst_mem_addr", mem_addr[0], 32'd0);
        check("t6_rst_mem_wen", 32'(mem_wen[0]), 32'd0);
        check("t6_rst_mem_wr", 32'(mem_wr[0]), 32'd0);
        check("t6_rst_d_data_ok", 32'(d_data_ok[0]), 32'd0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        d_req[0] = 0; mem_data_ok[0] = 1; mem_rdata[0] = 32'hCAFE_F00D;
        tick();
        check("t6_stray_ok", 32'(d_data_ok[0]), 32'd0);
        check("t6_stray_req", 32'(mem_req[0]), 32'd0);
        tick();
        check("t6_stray_ok2", 32'(d_data_ok[0]), 32'd0);
        check("t6_stray_rdata", d_rdata[0], 32'd0);
        mem_data_ok[0] = 0;
        tick();

        // randomized traffic on both instances
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < 2; k++) begin
                if (!i_req[k] || i_data_ok[k]) i_req[k] = ($urandom_range(0, 3) != 0);
                if (!d_req[k] || d_data_ok[k]) d_req[k] = ($urandom_range(0, 3) != 0);
                i_addr[k]      = $urandom();
                d_addr[k]      = $urandom();
                d_wdata[k]     = $urandom();
                d_wen[k]       = ($urandom_range(0, 1) != 0) ? 4'd0 : 4'($urandom_range(0, 15));
                mem_addr_ok[k] = ($urandom_range(0, 2) == 0);
                mem_data_ok[k] = ($urandom_range(0, 2) == 0);
                mem_rdata[k]   = $urandom();
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
